// File: rtl/lv_hv_pwm_pkg.sv
// Definitions shared by the HV-side PWM/INTB encoder and the LV-side intb decoder.
package lv_hv_pwm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEdge = 2'd1,
        StGap  = 2'd2
    } pwm_state_e;

    // Edge counts that encode the interrupt level on the line.
    localparam int unsigned ASSERT_EDGES   = 1;
    localparam int unsigned DEASSERT_EDGES = 3;

    // Decoder thresholds: edge debounce and burst timeout, in cycles.
    localparam int unsigned DN_TH = 4;
    localparam int unsigned UP_TH = 8;

    // Number of toggles that carry a given active-low interrupt level.
    function automatic logic [1:0] edge_target(input logic level);
        return level ? 2'(DEASSERT_EDGES) : 2'(ASSERT_EDGES);
    endfunction

endpackage

// File: rtl/hv_pwm_intb_encode.sv
// HV-side encoder: turns interrupt level changes into toggle bursts on the
// shared PWM/INTB line (1 toggle = assert, 3 toggles = de-assert), each
// followed by a quiet gap. An optional refresh re-sends the current level.
module hv_pwm_intb_encode
    import lv_hv_pwm_pkg::*;
#(
    parameter int unsigned EDGE_HOLD_CYC = 6,
    parameter int unsigned GAP_CYC       = 16,
    parameter int unsigned REFRESH_CYC   = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_intb_n,
    output logic o_hv_pwm_intb_n,
    output logic o_busy,
    output logic o_intb_n_sent,
    output logic o_burst_done
);

    localparam int unsigned CntMax = (GAP_CYC > REFRESH_CYC) ? GAP_CYC : REFRESH_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(EDGE_HOLD_CYC - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);
    localparam logic [CntW-1:0] RefLast  = CntW'((REFRESH_CYC == 0) ? 0 : REFRESH_CYC - 1);
    localparam bit RefreshOn = (REFRESH_CYC != 0);

    pwm_state_e      state_q;
    logic [CntW-1:0] hold_cnt_q;
    logic [CntW-1:0] ref_cnt_q;
    logic [1:0]      edge_cnt_q;
    logic [1:0]      target_q;
    logic            level_q;
    logic            line_q;
    logic            busy_q;
    logic            sent_q;
    logic            done_q;

    logic mismatch;
    logic refresh_hit;
    logic launch;

    // Launch decision, only acted on while idle.
    always_comb begin
        mismatch    = (i_intb_n != sent_q);
        refresh_hit = RefreshOn && (ref_cnt_q == RefLast);
        launch      = i_en && (mismatch || refresh_hit);
    end

    // Burst FSM with burst timer, refresh counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            ref_cnt_q  <= '0;
            edge_cnt_q <= '0;
            target_q   <= '0;
            level_q    <= 1'b1;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            sent_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        // Level is latched so input changes mid-burst are ignored.
                        level_q    <= i_intb_n;
                        target_q   <= edge_target(i_intb_n);
                        line_q     <= ~line_q;
                        edge_cnt_q <= 2'd1;
                        hold_cnt_q <= '0;
                        ref_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StEdge;
                    end else if (!i_en) begin
                        ref_cnt_q <= '0;
                    end else if (ref_cnt_q != RefLast) begin
                        ref_cnt_q <= ref_cnt_q + CntW'(1);
                    end
                end
                StEdge: begin
                    if (hold_cnt_q == HoldLast) begin
                        hold_cnt_q <= '0;
                        if (edge_cnt_q < target_q) begin
                            line_q     <= ~line_q;
                            edge_cnt_q <= edge_cnt_q + 2'd1;
                        end else begin
                            state_q <= StGap;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (hold_cnt_q == GapLast) begin
                        hold_cnt_q <= '0;
                        ref_cnt_q  <= '0;
                        sent_q     <= level_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Timing must satisfy the LV decoder's debounce and timeout windows.
    always_ff @(posedge i_clk) begin
        assert (EDGE_HOLD_CYC >= DN_TH && EDGE_HOLD_CYC < UP_TH)
            else $error("EDGE_HOLD_CYC outside decoder window");
        assert (GAP_CYC > UP_TH)
            else $error("GAP_CYC must exceed decoder timeout");
    end

    assign o_hv_pwm_intb_n = line_q;
    assign o_busy          = busy_q;
    assign o_intb_n_sent   = sent_q;
    assign o_burst_done    = done_q;

endmodule
